// File: rtl/can_rx_destuff.sv
// CAN bit-stream receiver: samples the synchronized bus at mid-bit, removes stuff bits
// up to the end of the CRC field and presents the fixed 108-bit destuffed frame.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a synchronized dominant level (armed after reset)
//   START | counting to the SOF mid-bit point, confirms or rejects SOF
//   DATA  | sampling one bit per bit time, destuffing and storing
//   DONE  | publishing the captured frame and pulsing o_Rx_DV
module can_rx_destuff #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic         i_Clock,
    input  logic         i_Rst_n,
    input  logic         i_Rx_Serial,
    output logic         o_Rx_DV,
    output logic [0:107] o_Rx_Byte,
    output logic         o_Stuff_Err,
    output logic         o_Rx_Active
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] BIT_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [6:0]    LAST_IDX       = 7'd107;
    localparam logic [6:0]    LAST_STUFF_IDX = 7'd98;

    typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;

    state_t         state_q, state_d;
    logic           sync1_q, sync1_d;
    logic           sync2_q, sync2_d;
    logic [1:0]     sync_vld_q, sync_vld_d;
    logic           armed_q, armed_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [6:0]     idx_q, idx_d;
    logic [2:0]     run_q, run_d;
    logic           run_val_q, run_val_d;
    logic [0:107]   shreg_q, shreg_d;
    logic [0:107]   byte_q, byte_d;
    logic           dv_q, dv_d;
    logic           err_q, err_d;
    logic           active_q, active_d;

    logic rx;
    assign rx = sync2_q;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            sync_vld_q <= 2'b00;
            armed_q    <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            run_q      <= '0;
            run_val_q  <= 1'b0;
            shreg_q    <= '0;
            byte_q     <= '0;
            dv_q       <= 1'b0;
            err_q      <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync_vld_q <= sync_vld_d;
            armed_q    <= armed_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            run_q      <= run_d;
            run_val_q  <= run_val_d;
            shreg_q    <= shreg_d;
            byte_q     <= byte_d;
            dv_q       <= dv_d;
            err_q      <= err_d;
            active_q   <= active_d;
        end
    end

    always_comb begin
        sync1_d    = i_Rx_Serial;
        sync2_d    = sync1_q;
        sync_vld_d = {sync_vld_q[0], 1'b1};
        // The preset synchronizer value must not arm the receiver; wait for a real recessive sample.
        armed_d    = armed_q | (sync_vld_q[1] & rx);
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        run_d      = run_q;
        run_val_d  = run_val_q;
        shreg_d    = shreg_q;
        byte_d     = byte_q;
        dv_d       = 1'b0;
        err_d      = 1'b0;
        active_d   = active_q;

        case (state_q)
            IDLE: begin
                if (!rx && armed_q) begin
                    state_d = START;
                    cnt_d   = HALF_CNT;
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!rx) begin
                    state_d   = DATA;
                    cnt_d     = BIT_CNT;
                    shreg_d   = {shreg_q[1:107], 1'b0};
                    idx_d     = 7'd1;
                    run_d     = 3'd1;
                    run_val_d = 1'b0;
                    active_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d = BIT_CNT;
                    // idx_q counts stored bits, so 98 still covers the stuff bit after CRC bit 97.
                    if (run_q == 3'd5 && idx_q <= LAST_STUFF_IDX) begin
                        if (rx != run_val_q) begin
                            run_d     = 3'd1;
                            run_val_d = rx;
                        end else begin
                            err_d    = 1'b1;
                            active_d = 1'b0;
                            state_d  = IDLE;
                        end
                    end else begin
                        shreg_d = {shreg_q[1:107], rx};
                        idx_d   = idx_q + 7'd1;
                        if (rx == run_val_q) begin
                            run_d = run_q + 3'd1;
                        end else begin
                            run_d     = 3'd1;
                            run_val_d = rx;
                        end
                        if (idx_q == LAST_IDX) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                byte_d   = shreg_q;
                dv_d     = 1'b1;
                active_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_Rx_DV     = dv_q;
    assign o_Rx_Byte   = byte_q;
    assign o_Stuff_Err = err_q;
    assign o_Rx_Active = active_q;

endmodule

// File: tb/tb_can_rx_destuff.sv
// Directed bench for can_rx_destuff: expected frames go into a queue when driven and are
// compared against o_Rx_Byte whenever o_Rx_DV pulses.
module tb_can_rx_destuff;

    localparam int C = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx_line = 1'b1;
    logic         dv;
    logic [0:107] rx_byte;
    logic         stuff_err;
    logic         active;

    int total = 0;
    int bad = 0;
    int dv_cnt = 0;
    int err_cnt = 0;
    bit active_seen = 1'b0;
    logic [0:107] exp_q[$];
    logic [0:107] base_vec;
    logic [0:107] stuff_vec;

    can_rx_destuff #(.CLKS_PER_BIT(C)) dut (
        .i_Clock    (clk),
        .i_Rst_n    (rst_n),
        .i_Rx_Serial(rx_line),
        .o_Rx_DV    (dv),
        .o_Rx_Byte  (rx_byte),
        .o_Stuff_Err(stuff_err),
        .o_Rx_Active(active)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [0:107] e;
        if (dv) begin
            dv_cnt++;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL dv_unexpected got=1 exp=0");
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                assert (rx_byte === e) else begin
                    bad++;
                    $error("FAIL rx_byte got=%h exp=%h", rx_byte, e);
                end
            end
        end
        if (stuff_err) err_cnt++;
        if (active) active_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_line = b;
        repeat (C) @(negedge clk);
    endtask

    task automatic send_frame(input logic [0:107] v, input bit stuff5);
        for (int i = 0; i < 108; i++) begin
            if (stuff5 && i == 5) send_bit(1'b1);
            send_bit(v[i]);
        end
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic clear_counts();
        dv_cnt = 0;
        err_cnt = 0;
        active_seen = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 98; i++) base_vec[i] = (i % 2 == 1);
        base_vec[98] = 1'b1;
        base_vec[99] = 1'b0;
        for (int i = 100; i < 108; i++) base_vec[i] = 1'b1;
        stuff_vec = base_vec;
        for (int i = 0; i < 5; i++) stuff_vec[i] = 1'b0;

        // reset with the line toggling
        @(negedge clk);
        for (int i = 0; i < 23; i++) begin
            rx_line = ~rx_line;
            @(negedge clk);
        end
        check("rst_dv", {127'd0, dv}, 128'd0);
        check("rst_err", {127'd0, stuff_err}, 128'd0);
        check("rst_active", {127'd0, active}, 128'd0);
        check("rst_byte", {20'd0, rx_byte}, 128'd0);
        check("rst_pulses", dv_cnt + err_cnt, 128'd0);
        rx_line = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        idle_bits(3);

        // unstuffed frame
        exp_q.push_back(base_vec);
        send_frame(base_vec, 1'b0);
        idle_bits(3);
        check("f1_dv_cnt", dv_cnt, 1);
        check("f1_err_cnt", err_cnt, 0);
        check("f1_active_seen", {127'd0, active_seen}, 128'd1);
        check("f1_active_end", {127'd0, active}, 128'd0);

        // stuffed frame
        clear_counts();
        exp_q.push_back(stuff_vec);
        send_frame(stuff_vec, 1'b1);
        idle_bits(3);
        check("f2_dv_cnt", dv_cnt, 1);
        check("f2_err_cnt", err_cnt, 0);

        // stuff error: six dominant bits from SOF
        clear_counts();
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        idle_bits(4);
        check("se_err_cnt", err_cnt, 1);
        check("se_dv_cnt", dv_cnt, 0);
        check("se_byte_kept", {20'd0, rx_byte}, {20'd0, stuff_vec});
        check("se_active", {127'd0, active}, 128'd0);

        // glitch shorter than half a bit
        clear_counts();
        rx_line = 1'b0;
        repeat (2) @(negedge clk);
        rx_line = 1'b1;
        repeat (3 * C) @(negedge clk);
        check("gl_active_seen", {127'd0, active_seen}, 128'd0);
        check("gl_dv_cnt", dv_cnt, 0);
        check("gl_err_cnt", err_cnt, 0);

        // reset mid-frame, released with the line dominant
        clear_counts();
        for (int i = 0; i < 50; i++) send_bit(base_vec[i]);
        rx_line = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mr_byte", {20'd0, rx_byte}, 128'd0);
        check("mr_active", {127'd0, active}, 128'd0);
        rst_n = 1'b1;
        active_seen = 1'b0;
        repeat (3 * C) @(negedge clk);
        check("mr_no_sof_low", {127'd0, active_seen}, 128'd0);
        idle_bits(2);
        exp_q.push_back(base_vec);
        send_frame(base_vec, 1'b0);
        idle_bits(3);
        check("mr_dv_cnt", dv_cnt, 1);
        check("mr_err_cnt", err_cnt, 0);

        // back-to-back frames with no idle gap after the last EOF bit
        clear_counts();
        exp_q.push_back(base_vec);
        exp_q.push_back(stuff_vec);
        send_frame(base_vec, 1'b0);
        send_frame(stuff_vec, 1'b1);
        idle_bits(3);
        check("b2b_dv_cnt", dv_cnt, 2);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/can_rx_destuff.md
CAN_RX_DESTUFF -- requirements
Module: can_rx_destuff

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10; clock cycles per CAN bit time (integer, at least 4).
REQ-002 SHALL have port i_Clock, input, 1, the single system clock; all logic is rising-edge.
REQ-003 SHALL have port i_Rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port i_Rx_Serial, input, 1; CAN bus level, 1 = recessive/idle, 0 = dominant.
REQ-005 SHALL have port o_Rx_DV, output, 1; one-cycle pulse when a complete frame is captured.
REQ-006 SHALL have port o_Rx_Byte, output, [0:107]; the last captured destuffed frame, bit 0 = SOF, bit 107 = last EOF bit.
REQ-007 SHALL have port o_Stuff_Err, output, 1; one-cycle pulse on a stuff-rule violation.
REQ-008 SHALL have port o_Rx_Active, output, 1; high from SOF detection until the frame ends or is aborted.

Function
REQ-009 SHALL pass i_Rx_Serial through a 2-flop synchronizer before any use.
REQ-010 SHALL implement states IDLE, START, DATA, DONE.
REQ-011 IDLE: on a synchronized 0, go to START and clear the clock counter.
REQ-012 START: after (CLKS_PER_BIT-1)/2 clocks, resample the line.
- If 0: valid SOF; capture it as frame bit 0 and go to DATA.
- If 1: glitch; return to IDLE with no outputs asserted.
REQ-013 DATA: sample one bit every CLKS_PER_BIT clocks after the SOF mid-bit sample.
REQ-014 The frame SHALL be a fixed 108 destuffed bits: SOF1, ID11, RTR, IDE, r0, DLC4, DATA64, CRC15, CRC delimiter, ACK, ACK delimiter, EOF7. DLC contents SHALL be ignored.
REQ-015 Destuff region: serial bits from SOF up to and including the stuff bit following frame bit 97 (last CRC bit).
REQ-016 Destuffing SHALL keep a run counter of consecutive equal samples; SOF starts the run at 1.
- When the run reaches 5, the next sample is a stuff bit and is not stored.
- If the stuff bit differs from the run value: reset the run to 1 with the stuff-bit value.
- If the stuff bit equals the run value: pulse o_Stuff_Err one cycle after the sample, deassert o_Rx_Active and go to IDLE. o_Rx_Byte is unchanged and o_Rx_DV is not pulsed.
REQ-017 Frame bits 98..107 SHALL never be destuffed; the run counter is ignored there.
REQ-018 Stored bits SHALL shift into an internal 108-bit register in arrival order. A bit index counter SHALL count only stored (non-stuff) bits.
REQ-019 After frame bit 107 is sampled, go to DONE. The next cycle SHALL copy the register to o_Rx_Byte, pulse o_Rx_DV for exactly one cycle, deassert o_Rx_Active and return to IDLE.
REQ-020 No form or CRC checking SHALL be performed; EOF values are stored as received.
REQ-021 A new SOF SHALL be accepted on the first synchronized 0 seen in IDLE, including immediately after DONE.

Reset
REQ-022 While i_Rst_n=0, all of the following SHALL be 0: o_Rx_DV, o_Stuff_Err, o_Rx_Active, o_Rx_Byte, the shift register, the counters and the synchronizer (which presets to 1). State SHALL be IDLE.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame. After release, the block SHALL wait for a fresh SOF, even if the line is 0 at release, until the line first reads 1.

Verification
REQ-024 Reset: assert i_Rst_n=0 with the line toggling -> all outputs 0, no pulses.
REQ-025 Unstuffed frame: drive frame bits 0..97 = 0,1,0,1,... alternating, then bits 98..107 = 1,0,1,1,1,1,1,1,1,1, each held CLKS_PER_BIT clocks (108 bit times). Required: one o_Rx_DV pulse, o_Rx_Byte equal to that vector, o_Stuff_Err never pulses.
REQ-026 Stuffed frame: frame bits 0..4 = 00000, with a stuff 1 inserted on the line before frame bit 5; remaining bits as in REQ-025 (109 serial bits). Required: o_Rx_DV pulse and o_Rx_Byte equal to the 108-bit unstuffed vector.
REQ-027 Stuff error: drive six consecutive 0 bits from SOF. Required: o_Stuff_Err pulses once after the 6th sample, no o_Rx_DV, o_Rx_Byte retains its previous value.
REQ-028 Glitch: line 0 for 2 clocks then 1 (CLKS_PER_BIT=10). Required: no o_Rx_Active at the mid-bit sample, no outputs.
REQ-029 Reset mid-frame at bit 50, then a full REQ-025 frame. Required: exactly one o_Rx_DV pulse, with the correct vector.
